// File: rtl/xpt_sequencer.sv
// Execution-phase sequencer: fetches the opcode, counts decoder phases (XPT) and runs bus cycles.
// Optional macro XPT_WAIT_EN: honour mem_ready wait states; otherwise every bus cycle lasts one clock.
module xpt_sequencer #(
   parameter int XPT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   output logic             enable,
   output logic [XPT_W-1:0] XPT,
   output logic [XPT_W-1:0] notXPT,
   output logic [7:0]       Source,
   output logic [7:0]       notSource,
   input  logic             PR_Reset_XPT,
   input  logic             P2_Set_CM1,
   input  logic             PC_R0,
   input  logic             PC_R1,
   input  logic             PC_R2,
   input  logic             PC_W0,
   input  logic             PC_W1,
   input  logic             PC_W2,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             mem_m1,
   output logic [1:0]       mem_slot,
   input  logic             mem_ready,
   input  logic [7:0]       mem_rdata,
   output logic [7:0]       opr0,
   output logic [7:0]       opr1,
   output logic [7:0]       opr2,
   output logic             xpt_overflow,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_MEM   = 2'd3
   } state_t;

   localparam logic [XPT_W-1:0] XPT_ONE = 1;

   state_t           state_q, state_d;
   logic [XPT_W-1:0] xpt_q, xpt_d;
   logic [7:0]       src_q, src_d;
   logic             en_q, en_d;
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic             m1_q, m1_d;
   logic [1:0]       slot_q, slot_d;
   logic             ovf_q, ovf_d;
   logic             pend_q, pend_d;
   logic [7:0]       opr0_q, opr0_d;
   logic [7:0]       opr1_q, opr1_d;
   logic [7:0]       opr2_q, opr2_d;

   logic             bus_ready;
   logic             rw_any;
   logic             rw_is_wr;
   logic [1:0]       rw_slot;
   logic [XPT_W-1:0] xpt_inc;
   logic             xpt_max;

`ifdef XPT_WAIT_EN
   assign bus_ready = mem_ready;
`else
   logic unused_ready;
   assign unused_ready = mem_ready;
   assign bus_ready    = 1'b1;
`endif

   assign xpt_inc = xpt_q + XPT_ONE;
   assign xpt_max = (xpt_q == {XPT_W{1'b1}});

   // Lowest slot wins; at equal slot a read beats a write.
   always_comb begin
      rw_any   = 1'b1;
      rw_is_wr = 1'b0;
      rw_slot  = 2'd0;
      if (PC_R0) begin
         rw_slot = 2'd0;
      end else if (PC_W0) begin
         rw_slot  = 2'd0;
         rw_is_wr = 1'b1;
      end else if (PC_R1) begin
         rw_slot = 2'd1;
      end else if (PC_W1) begin
         rw_slot  = 2'd1;
         rw_is_wr = 1'b1;
      end else if (PC_R2) begin
         rw_slot = 2'd2;
      end else if (PC_W2) begin
         rw_slot  = 2'd2;
         rw_is_wr = 1'b1;
      end else begin
         rw_any = 1'b0;
      end
   end

   // Bus handshake: mem_rd/mem_wr act as valid and stay high with a stable mem_slot
   // until mem_ready is seen high; the transfer completes on that rising edge.
   always_comb begin
      state_d = state_q;
      xpt_d   = xpt_q;
      src_d   = src_q;
      en_d    = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      m1_d    = 1'b0;
      slot_d  = 2'd0;
      ovf_d   = 1'b0;
      pend_d  = pend_q;
      opr0_d  = opr0_q;
      opr1_d  = opr1_q;
      opr2_d  = opr2_q;
      case (state_q)
         ST_RST: begin
            state_d = ST_FETCH;
            rd_d    = 1'b1;
            m1_d    = 1'b1;
         end
         ST_FETCH: begin
            if (bus_ready) begin
               src_d   = mem_rdata;
               xpt_d   = '0;
               state_d = ST_EXEC;
               en_d    = 1'b1;
            end else begin
               rd_d = 1'b1;
               m1_d = 1'b1;
            end
         end
         ST_EXEC: begin
            if (P2_Set_CM1) begin
               state_d = ST_FETCH;
               xpt_d   = '0;
               rd_d    = 1'b1;
               m1_d    = 1'b1;
            end else if (rw_any) begin
               state_d = ST_MEM;
               slot_d  = rw_slot;
               rd_d    = ~rw_is_wr;
               wr_d    = rw_is_wr;
               pend_d  = PR_Reset_XPT;
            end else if (PR_Reset_XPT) begin
               xpt_d = '0;
               en_d  = 1'b1;
            end else begin
               xpt_d = xpt_inc;
               ovf_d = xpt_max;
               en_d  = 1'b1;
            end
         end
         ST_MEM: begin
            if (bus_ready) begin
               if (rd_q) begin
                  case (slot_q)
                     2'd0:    opr0_d = mem_rdata;
                     2'd1:    opr1_d = mem_rdata;
                     2'd2:    opr2_d = mem_rdata;
                     default: ;
                  endcase
               end
               // A PR_Reset_XPT seen alongside the R/W strobe takes effect here.
               xpt_d   = pend_q ? '0 : xpt_inc;
               ovf_d   = ~pend_q & xpt_max;
               pend_d  = 1'b0;
               state_d = ST_EXEC;
               en_d    = 1'b1;
            end else begin
               rd_d   = rd_q;
               wr_d   = wr_q;
               slot_d = slot_q;
            end
         end
         default: state_d = ST_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RST;
         xpt_q   <= '0;
         src_q   <= 8'h00;
         en_q    <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         m1_q    <= 1'b0;
         slot_q  <= 2'd0;
         ovf_q   <= 1'b0;
         pend_q  <= 1'b0;
         opr0_q  <= 8'h00;
         opr1_q  <= 8'h00;
         opr2_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         xpt_q   <= xpt_d;
         src_q   <= src_d;
         en_q    <= en_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         m1_q    <= m1_d;
         slot_q  <= slot_d;
         ovf_q   <= ovf_d;
         pend_q  <= pend_d;
         opr0_q  <= opr0_d;
         opr1_q  <= opr1_d;
         opr2_q  <= opr2_d;
      end
   end

   // Complements are derived from the same registers so they can never diverge.
   assign enable       = en_q;
   assign XPT          = xpt_q;
   assign notXPT       = ~xpt_q;
   assign Source       = src_q;
   assign notSource    = ~src_q;
   assign mem_rd       = rd_q;
   assign mem_wr       = wr_q;
   assign mem_m1       = m1_q;
   assign mem_slot     = slot_q;
   assign opr0         = opr0_q;
   assign opr1         = opr1_q;
   assign opr2         = opr2_q;
   assign xpt_overflow = ovf_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_xpt_sequencer.sv
// Self-checking bench for xpt_sequencer: directed scenarios plus a randomized
// instruction-level run checked against a transaction model.
module tb_xpt_sequencer;

`ifdef XPT_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [4:0] XPT, notXPT;
   logic [7:0] Source, notSource;
   logic       PR_Reset_XPT, P2_Set_CM1;
   logic       PC_R0, PC_R1, PC_R2, PC_W0, PC_W1, PC_W2;
   logic       mem_rd, mem_wr, mem_m1;
   logic [1:0] mem_slot;
   logic       mem_ready;
   logic [7:0] mem_rdata;
   logic [7:0] opr0, opr1, opr2;
   logic       xpt_overflow;
   logic [1:0] dbg_state;

   int         n_vec = 0;
   int         n_err = 0;

   // transaction-level model state
   int         m_xpt;
   logic [7:0] m_src;
   logic [7:0] m_opr [3];

   always #5 clk = ~clk;

   xpt_sequencer #(.XPT_W(5)) dut (
      .clk(clk), .reset(reset), .enable(enable), .XPT(XPT), .notXPT(notXPT),
      .Source(Source), .notSource(notSource), .PR_Reset_XPT(PR_Reset_XPT),
      .P2_Set_CM1(P2_Set_CM1), .PC_R0(PC_R0), .PC_R1(PC_R1), .PC_R2(PC_R2),
      .PC_W0(PC_W0), .PC_W1(PC_W1), .PC_W2(PC_W2), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_m1(mem_m1), .mem_slot(mem_slot),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .opr0(opr0), .opr1(opr1),
      .opr2(opr2), .xpt_overflow(xpt_overflow), .dbg_state(dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // bit0=R0 bit1=W0 bit2=R1 bit3=W1 bit4=R2 bit5=W2
   task automatic set_rw(input logic [5:0] b);
      {PC_W2, PC_R2, PC_W1, PC_R1, PC_W0, PC_R0} = b;
   endtask

   task automatic clear_strobes();
      set_rw(6'b0);
      PR_Reset_XPT = 1'b0;
      P2_Set_CM1   = 1'b0;
   endtask

   // Drives an opcode fetch starting in a FETCH cycle; leaves the DUT in EXEC.
   task automatic fetch_op(input logic [7:0] op, input int waits);
      int w;
      w = WAIT_EN ? waits : 0;
      for (int i = 0; i <= w; i++) begin
         mem_ready = (i == w);
         mem_rdata = (i == w) ? op : 8'($urandom);
         tick();
      end
      mem_ready = 1'b0;
      m_src = op;
      m_xpt = 0;
   endtask

   task automatic zero_xpt();
      PR_Reset_XPT = 1'b1;
      tick();
      PR_Reset_XPT = 1'b0;
      m_xpt = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_strobes();
      mem_ready = 1'b0;
      mem_rdata = 8'h00;
      tick();
      tick();
      n_vec++;
      if ({enable, mem_rd, mem_wr, mem_m1, mem_slot, xpt_overflow} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_ctl: got %b want 0000000", {enable, mem_rd, mem_wr, mem_m1, mem_slot, xpt_overflow});
      end
      n_vec++;
      if ({XPT, notXPT} !== {5'h00, 5'h1F}) begin
         n_err++;
         $display("FAIL reset_xpt: got XPT=%h notXPT=%h want 00/1f", XPT, notXPT);
      end
      n_vec++;
      if ({Source, notSource} !== {8'h00, 8'hFF}) begin
         n_err++;
         $display("FAIL reset_src: got Source=%h notSource=%h want 00/ff", Source, notSource);
      end
      n_vec++;
      if ({opr0, opr1, opr2} !== 24'h0) begin
         n_err++;
         $display("FAIL reset_opr: got %h want 000000", {opr0, opr1, opr2});
      end
      mem_ready = 1'b1;
      mem_rdata = 8'h02;
      reset     = 1'b0;
      tick();
      n_vec++;
      if ({enable, mem_rd, mem_m1} !== 3'b011) begin
         n_err++;
         $display("FAIL release_fetch: got en/rd/m1=%b want 011", {enable, mem_rd, mem_m1});
      end
      tick();
      mem_ready = 1'b0;
      n_vec++;
      if ({enable, Source, notSource, XPT} !== {1'b1, 8'h02, 8'hFD, 5'd0}) begin
         n_err++;
         $display("FAIL first_opcode: got en=%b Source=%h notSource=%h XPT=%0d want 1/02/fd/0", enable, Source, notSource, XPT);
      end
      m_src = 8'h02;
      m_xpt = 0;
      for (int i = 0; i < 3; i++) m_opr[i] = 8'h00;
   endtask

   task automatic test_read_wait();
      int w;
      w = WAIT_EN ? 2 : 0;
      zero_xpt();
      for (int i = 0; i < 3; i++) tick();
      n_vec++;
      if (XPT !== 5'd3) begin
         n_err++;
         $display("FAIL idle_count: got XPT=%0d want 3", XPT);
      end
      PC_R1 = 1'b1;
      tick();
      PC_R1 = 1'b0;
      for (int i = 0; i <= w; i++) begin
         n_vec++;
         if ({enable, mem_rd, mem_wr, mem_slot, XPT} !== {1'b0, 1'b1, 1'b0, 2'd1, 5'd3}) begin
            n_err++;
            $display("FAIL read_mem_phase%0d: got en=%b rd=%b wr=%b slot=%0d XPT=%0d want 0/1/0/1/3", i, enable, mem_rd, mem_wr, mem_slot, XPT);
         end
         mem_ready = (i == w);
         mem_rdata = 8'hA5;
         tick();
      end
      mem_ready = 1'b0;
      n_vec++;
      if ({enable, mem_rd, opr1, XPT} !== {1'b1, 1'b0, 8'hA5, 5'd4}) begin
         n_err++;
         $display("FAIL read_done: got en=%b rd=%b opr1=%h XPT=%0d want 1/0/a5/4", enable, mem_rd, opr1, XPT);
      end
      m_opr[1] = 8'hA5;
      m_xpt = 4;
   endtask

   task automatic test_p2_priority();
      tick();
      tick();
      P2_Set_CM1   = 1'b1;
      PC_W0        = 1'b1;
      PR_Reset_XPT = 1'b1;
      tick();
      clear_strobes();
      n_vec++;
      if ({enable, mem_rd, mem_wr, mem_m1, XPT} !== {1'b0, 1'b1, 1'b0, 1'b1, 5'd0}) begin
         n_err++;
         $display("FAIL p2_fetch: got en=%b rd=%b wr=%b m1=%b XPT=%0d want 0/1/0/1/0", enable, mem_rd, mem_wr, mem_m1, XPT);
      end
      fetch_op(8'h7E, 1);
      n_vec++;
      if ({enable, Source, XPT} !== {1'b1, 8'h7E, 5'd0}) begin
         n_err++;
         $display("FAIL p2_refetch: got en=%b Source=%h XPT=%0d want 1/7e/0", enable, Source, XPT);
      end
   endtask

   task automatic test_rw_priority();
      zero_xpt();
      PC_R2 = 1'b1;
      tick();
      PC_R2     = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 8'h3C;
      tick();
      mem_ready = 1'b0;
      n_vec++;
      if ({opr2, XPT} !== {8'h3C, 5'd1}) begin
         n_err++;
         $display("FAIL opr2_load: got opr2=%h XPT=%0d want 3c/1", opr2, XPT);
      end
      PC_R2 = 1'b1;
      PC_W0 = 1'b1;
      tick();
      clear_strobes();
      n_vec++;
      if ({mem_rd, mem_wr, mem_slot} !== {1'b0, 1'b1, 2'd0}) begin
         n_err++;
         $display("FAIL rw_prio: got rd=%b wr=%b slot=%0d want 0/1/0", mem_rd, mem_wr, mem_slot);
      end
      mem_ready = 1'b1;
      mem_rdata = 8'hC3;
      tick();
      mem_ready = 1'b0;
      n_vec++;
      if ({enable, opr2, opr0, XPT} !== {1'b1, 8'h3C, 8'h00, 5'd2}) begin
         n_err++;
         $display("FAIL write_no_load: got en=%b opr2=%h opr0=%h XPT=%0d want 1/3c/00/2", enable, opr2, opr0, XPT);
      end
      m_opr[2] = 8'h3C;
      m_xpt = 2;
   endtask

   task automatic test_wrap();
      int pulses;
      pulses = 0;
      zero_xpt();
      for (int i = 0; i < 32; i++) begin
         tick();
         if (xpt_overflow === 1'b1) pulses++;
         n_vec++;
         if ({XPT, xpt_overflow} !== {5'((i + 1) % 32), (i == 31)}) begin
            n_err++;
            $display("FAIL wrap_step%0d: got XPT=%0d ovf=%b want %0d/%b", i, XPT, xpt_overflow, (i + 1) % 32, (i == 31));
         end
      end
      n_vec++;
      if (pulses !== 1) begin
         n_err++;
         $display("FAIL wrap_pulses: got %0d want 1", pulses);
      end
      m_xpt = 0;
   endtask

   task automatic test_reset_mid_mem();
      PC_W2 = 1'b1;
      mem_ready = 1'b0;
      tick();
      PC_W2 = 1'b0;
      n_vec++;
      if ({mem_wr, mem_slot} !== {1'b1, 2'd2}) begin
         n_err++;
         $display("FAIL mid_mem_wr: got wr=%b slot=%0d want 1/2", mem_wr, mem_slot);
      end
      reset = 1'b1;
      tick();
      n_vec++;
      if ({mem_wr, mem_rd, enable, Source} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL mid_mem_reset: got wr=%b rd=%b en=%b Source=%h want 0/0/0/00", mem_wr, mem_rd, enable, Source);
      end
      reset = 1'b0;
      tick();
      n_vec++;
      if ({mem_rd, mem_m1, enable} !== 3'b110) begin
         n_err++;
         $display("FAIL refetch_start: got rd/m1/en=%b want 110", {mem_rd, mem_m1, enable});
      end
      for (int i = 0; i < 3; i++) m_opr[i] = 8'h00;
      fetch_op(8'h91, 0);
      n_vec++;
      if ({enable, Source, opr0, opr1, opr2} !== {1'b1, 8'h91, 24'h0}) begin
         n_err++;
         $display("FAIL refetch_done: got en=%b Source=%h opr=%h want 1/91/000000", enable, Source, {opr0, opr1, opr2});
      end
   endtask

   task automatic test_random(input int n_ops);
      for (int t = 0; t < n_ops; t++) begin
         int         kind;
         int         win;
         int         w;
         int         slot;
         logic       pr;
         logic       is_wr;
         logic       exp_ovf;
         logic [5:0] b;
         logic [7:0] data;
         kind = $urandom_range(0, 9);
         pr   = 1'($urandom_range(0, 1));
         if (kind == 0) begin
            P2_Set_CM1   = 1'b1;
            PR_Reset_XPT = pr;
            set_rw(6'($urandom_range(0, 63)));
            tick();
            clear_strobes();
            n_vec++;
            if ({enable, mem_rd, mem_wr, mem_m1, XPT} !== {1'b0, 1'b1, 1'b0, 1'b1, 5'd0}) begin
               n_err++;
               $display("FAIL rnd_p2 op%0d: got en=%b rd=%b wr=%b m1=%b XPT=%0d", t, enable, mem_rd, mem_wr, mem_m1, XPT);
            end
            data = 8'($urandom);
            fetch_op(data, $urandom_range(0, 3));
            n_vec++;
            if ({enable, Source, notSource, XPT, xpt_overflow} !== {1'b1, m_src, ~m_src, 5'd0, 1'b0}) begin
               n_err++;
               $display("FAIL rnd_fetch op%0d: got en=%b Source=%h notSource=%h XPT=%0d want Source=%h", t, enable, Source, notSource, XPT, m_src);
            end
         end else if (kind <= 4) begin
            b = 6'($urandom_range(1, 63));
            win = 0;
            for (int i = 5; i >= 0; i--) if (b[i]) win = i;
            slot  = win / 2;
            is_wr = (win % 2) == 1;
            set_rw(b);
            PR_Reset_XPT = pr;
            tick();
            clear_strobes();
            w    = WAIT_EN ? $urandom_range(0, 3) : 0;
            data = 8'($urandom);
            for (int i = 0; i <= w; i++) begin
               n_vec++;
               if ({enable, mem_rd, mem_wr, mem_m1, mem_slot, XPT} !== {1'b0, ~is_wr, is_wr, 1'b0, 2'(slot), 5'(m_xpt)}) begin
                  n_err++;
                  $display("FAIL rnd_mem op%0d w%0d: got en=%b rd=%b wr=%b m1=%b slot=%0d XPT=%0d want slot=%0d wr=%b XPT=%0d", t, i, enable, mem_rd, mem_wr, mem_m1, mem_slot, XPT, slot, is_wr, m_xpt);
               end
               mem_ready = (i == w);
               mem_rdata = (i == w) ? data : 8'($urandom);
               tick();
            end
            mem_ready = 1'b0;
            if (!is_wr) m_opr[slot] = data;
            exp_ovf = !pr && (m_xpt == 31);
            m_xpt   = pr ? 0 : (m_xpt + 1) % 32;
            n_vec++;
            if ({enable, mem_rd, mem_wr, XPT, notXPT, xpt_overflow} !== {1'b1, 1'b0, 1'b0, 5'(m_xpt), ~5'(m_xpt), exp_ovf}) begin
               n_err++;
               $display("FAIL rnd_mem_done op%0d: got en=%b rd=%b wr=%b XPT=%0d ovf=%b want XPT=%0d ovf=%b", t, enable, mem_rd, mem_wr, XPT, xpt_overflow, m_xpt, exp_ovf);
            end
            n_vec++;
            if ({opr0, opr1, opr2} !== {m_opr[0], m_opr[1], m_opr[2]}) begin
               n_err++;
               $display("FAIL rnd_opr op%0d: got %h %h %h want %h %h %h", t, opr0, opr1, opr2, m_opr[0], m_opr[1], m_opr[2]);
            end
         end else begin
            PR_Reset_XPT = pr;
            tick();
            clear_strobes();
            exp_ovf = !pr && (m_xpt == 31);
            m_xpt   = pr ? 0 : (m_xpt + 1) % 32;
            n_vec++;
            if ({enable, mem_rd, mem_wr, XPT, notXPT, xpt_overflow, Source} !== {1'b1, 1'b0, 1'b0, 5'(m_xpt), ~5'(m_xpt), exp_ovf, m_src}) begin
               n_err++;
               $display("FAIL rnd_idle op%0d: got en=%b XPT=%0d notXPT=%h ovf=%b Source=%h want XPT=%0d ovf=%b Source=%h", t, enable, XPT, notXPT, xpt_overflow, Source, m_xpt, exp_ovf, m_src);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_wait();
      test_p2_priority();
      test_rw_priority();
      test_wrap();
      test_reset_mid_mem();
      test_random(300);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/xpt_sequencer.md
# xpt_sequencer

Execution-phase sequencer for the instruction decoder tree. It fetches the opcode byte, presents `Source`/`notSource` and the phase count `XPT`/`notXPT` to the decoder, and drives its `enable`. It consumes the decoder's control strobes (`PR_Reset_XPT`, `P2_Set_CM1`, `PC_R0..2`, `PC_W0..2`) and turns them into phase advance, M1 re-entry and memory bus handshakes.

## Interface
Parameters
- `XPT_W`, 5: phase counter width; fixed to match the decoder.

Ports
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  out  1  decoder enable; high only in EXEC.
- `XPT` / `notXPT`  out  5 / 5  phase count and its bitwise complement.
- `Source` / `notSource`  out  8 / 8  latched opcode and its complement.
- `PR_Reset_XPT`  in  1  decoder request: phase returns to 0.
- `P2_Set_CM1`  in  1  decoder request: instruction done, start the next M1 fetch.
- `PC_R0`, `PC_R1`, `PC_R2`  in  1 each  read cycle into operand latch 0/1/2.
- `PC_W0`, `PC_W1`, `PC_W2`  in  1 each  write cycle, data slot 0/1/2.
- `mem_rd`, `mem_wr`  out  1 each  bus cycle strobes, held until ready.
- `mem_m1`  out  1  marks an opcode-fetch read.
- `mem_slot`  out  2  slot index of the current R/W cycle (0..2).
- `mem_ready`  in  1  bus completes this cycle.
- `mem_rdata`  in  8  read data, sampled when `mem_ready` is high.
- `opr0`, `opr1`, `opr2`  out  8 each  operand latches.
- `xpt_overflow`  out  1  one-cycle pulse on an XPT wrap.

## Operation
- States: RST, FETCH, EXEC, MEM.
- RST: entered on `reset`. All outputs are 0, except `notXPT` = 5'h1F and `notSource` = 8'hFF. Leaves for FETCH on the first cycle with `reset` low.
- FETCH: `mem_rd` = 1, `mem_m1` = 1, `enable` = 0.
  - On `mem_ready`: `Source` <= `mem_rdata`, `XPT` <= 0, go to EXEC.
- EXEC: `enable` = 1. Decoder strobes are evaluated every cycle, in this priority order:
  1. `P2_Set_CM1`: go to FETCH, `XPT` <= 0. Any concurrent R/W or reset strobe is ignored.
  2. Any `PC_Rn`/`PC_Wn`: latch the slot n and the direction, then go to MEM. `XPT` is held.
  3. `PR_Reset_XPT`: `XPT` <= 0.
  4. Otherwise: `XPT` <= `XPT` + 1, modulo 32. A wrap from 31 to 0 pulses `xpt_overflow`.
- More than one R/W strobe in the same cycle: the lowest index wins; reads win over writes at equal index.
- MEM: `enable` = 0. `mem_rd` or `mem_wr` is driven, with `mem_slot` = n.
  - On `mem_ready`: a read loads `oprn` <= `mem_rdata`. Then return to EXEC with `XPT` <= `XPT` + 1. A `PR_Reset_XPT` deferred from the issuing cycle gives 0 instead.
- `notXPT`/`notSource` are always the exact complement of the registered values, never a separate register that can diverge.
- `reset` in any state aborts any bus cycle: the strobes drop in the next cycle and the block enters RST.

## Timing
- Registered outputs only; no combinational path from decoder strobes to `mem_*`.
- Reset release at cycle 0: `mem_rd`/`mem_m1` are high from cycle 1.
- Fetch with zero wait: `mem_ready` sampled at cycle k gives `enable` = 1, `XPT` = 0 and valid `Source` at k+1.
- EXEC strobe at cycle k: bus strobe at k+1. Completion at j gives EXEC at j+1 with the new `XPT`.
- `P2_Set_CM1` at k: `mem_rd`/`mem_m1` at k+1. Minimum 2-cycle opcode-to-opcode for a one-phase instruction with zero-wait memory.
- `opr*` update at the edge after `mem_ready`. Values persist until overwritten or reset.

## Configuration
- `XPT_WAIT_EN` defined: `mem_ready` is honoured in FETCH and MEM; bus cycles last 1+ cycles.
- Not defined: `mem_ready` is ignored and treated as constantly 1. FETCH and MEM last exactly one cycle, and the port remains present but unused.

## Test plan
- Reset release, `mem_ready` = 1, `mem_rdata` = 8'h02: `Source` = 8'h02, `notSource` = 8'hFD, `XPT` = 0, `enable` = 1 at cycle 2.
- EXEC with `PC_R1` at XPT = 3, two wait cycles, `mem_rdata` = 8'hA5: `mem_rd` = 1 and `mem_slot` = 1 for 3 cycles. Then `opr1` = 8'hA5 and `XPT` = 4; `enable` is low throughout MEM.
- `P2_Set_CM1` with simultaneous `PC_W0` and `PR_Reset_XPT`: no `mem_wr`; next cycle `mem_rd` = `mem_m1` = 1 and `XPT` = 0.
- `PC_R2` with `PC_W0` in the same cycle: write cycle with `mem_slot` = 0; `opr2` is unchanged.
- EXEC held with no strobes for 32 cycles from XPT = 0: `XPT` wraps 31 -> 0 and `xpt_overflow` pulses exactly once.
- `reset` asserted mid-MEM with `mem_wr` high: `mem_wr` = 0, `enable` = 0 and `Source` = 0 next cycle. Refetch begins one cycle after release.
